// File: rtl/meta_info_dispatcher.sv
// rtl/meta_info_dispatcher.sv - credit-limited one-entry dispatcher to seq/shuffle consumers (option: META_DISPATCH_PERF_EN)
module meta_info_dispatcher #(
    parameter type         meta_ctrl_t    = logic,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       meta_info_valid_i,
    output logic       meta_info_ready_o,
    input  meta_ctrl_t meta_info_i,
    output logic       seq_valid_o,
    input  logic       seq_ready_i,
    output meta_ctrl_t seq_o,
    input  logic       seq_done_i,
    output logic       shf_valid_o,
    input  logic       shf_ready_i,
    output meta_ctrl_t shf_o,
    input  logic       shf_done_i,
    output logic       idle_o,
    output logic       err_o
`ifdef META_DISPATCH_PERF_EN
    ,
    output logic [31:0] stall_seq_cnt_o,
    output logic [31:0] stall_shf_cnt_o
`endif
);

    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic            full_q;
    meta_ctrl_t      data_q;
    logic            seq_sent_q, shf_sent_q;
    logic [CntW-1:0] seq_cnt_q, shf_cnt_q;
    logic            err_q;

    logic seq_hs, shf_hs, retire, accept;
    logic seq_credit, shf_credit;

    assign seq_credit = (seq_cnt_q < CntMax);
    assign shf_credit = (shf_cnt_q < CntMax);

    assign seq_valid_o = full_q & ~seq_sent_q & seq_credit;
    assign shf_valid_o = full_q & ~shf_sent_q & shf_credit;
    assign seq_o       = data_q;
    assign shf_o       = data_q;

    assign seq_hs = seq_valid_o & seq_ready_i;
    assign shf_hs = shf_valid_o & shf_ready_i;

    // Retire bypass into ready keeps a sustained stream at one entry per cycle.
    assign retire            = full_q & (seq_sent_q | seq_hs) & (shf_sent_q | shf_hs);
    assign meta_info_ready_o = ~full_q | retire;
    assign accept            = meta_info_valid_i & meta_info_ready_o;

    assign idle_o = ~full_q & (seq_cnt_q == '0) & (shf_cnt_q == '0);
    assign err_o  = err_q;

    function automatic logic [CntW-1:0] next_cnt(input logic [CntW-1:0] cnt,
                                                 input logic hs, input logic done);
        logic [CntW-1:0] res;
        res = cnt;
        if (hs && !done) begin
            res = cnt + 1'b1;
        end else if (!hs && done && cnt != '0) begin
            res = cnt - 1'b1;
        end
        return res;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q     <= 1'b0;
            data_q     <= '0;
            seq_sent_q <= 1'b0;
            shf_sent_q <= 1'b0;
        end else if (accept) begin
            full_q     <= 1'b1;
            data_q     <= meta_info_i;
            seq_sent_q <= 1'b0;
            shf_sent_q <= 1'b0;
        end else if (retire) begin
            full_q     <= 1'b0;
            seq_sent_q <= 1'b0;
            shf_sent_q <= 1'b0;
        end else begin
            if (seq_hs) seq_sent_q <= 1'b1;
            if (shf_hs) shf_sent_q <= 1'b1;
        end
    end

    // A done pulse with nothing in flight is a consumer protocol violation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seq_cnt_q <= '0;
            shf_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            seq_cnt_q <= next_cnt(seq_cnt_q, seq_hs, seq_done_i);
            shf_cnt_q <= next_cnt(shf_cnt_q, shf_hs, shf_done_i);
            if ((seq_done_i && !seq_hs && seq_cnt_q == '0) ||
                (shf_done_i && !shf_hs && shf_cnt_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef META_DISPATCH_PERF_EN
    logic [31:0] stall_seq_q, stall_shf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_seq_q <= '0;
            stall_shf_q <= '0;
        end else begin
            if (full_q && !seq_sent_q && !seq_credit && stall_seq_q != 32'hFFFF_FFFF)
                stall_seq_q <= stall_seq_q + 32'd1;
            if (full_q && !shf_sent_q && !shf_credit && stall_shf_q != 32'hFFFF_FFFF)
                stall_shf_q <= stall_shf_q + 32'd1;
        end
    end

    assign stall_seq_cnt_o = stall_seq_q;
    assign stall_shf_cnt_o = stall_shf_q;
`endif

endmodule

// File: tb/tb_meta_info_dispatcher.sv
// tb/tb_meta_info_dispatcher.sv - scoreboard bench for meta_info_dispatcher
module tb_meta_info_dispatcher;

    localparam int MAXO = 4;
    typedef logic [7:0] payload_t;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     in_valid = 1'b0;
    logic     in_ready;
    payload_t in_data = '0;
    logic     seq_valid, seq_ready = 1'b0, seq_done = 1'b0;
    logic     shf_valid, shf_ready = 1'b0, shf_done = 1'b0;
    payload_t seq_data, shf_data;
    logic     idle, err;
`ifdef META_DISPATCH_PERF_EN
    logic [31:0] stall_seq, stall_shf;
`endif

    always #5 clk = ~clk;

    meta_info_dispatcher #(.meta_ctrl_t(payload_t), .MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .meta_info_valid_i(in_valid), .meta_info_ready_o(in_ready), .meta_info_i(in_data),
        .seq_valid_o(seq_valid), .seq_ready_i(seq_ready), .seq_o(seq_data), .seq_done_i(seq_done),
        .shf_valid_o(shf_valid), .shf_ready_i(shf_ready), .shf_o(shf_data), .shf_done_i(shf_done),
        .idle_o(idle), .err_o(err)
`ifdef META_DISPATCH_PERF_EN
        , .stall_seq_cnt_o(stall_seq), .stall_shf_cnt_o(stall_shf)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: entries owed to each consumer, and entries each consumer holds.
    payload_t seq_q[$];
    payload_t shf_q[$];
    int       seq_infl = 0;
    int       shf_infl = 0;
    logic     mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_sv, exp_fv, s_hs, f_hs;
            exp_sv = (seq_q.size() > 0) && (seq_infl < MAXO);
            exp_fv = (shf_q.size() > 0) && (shf_infl < MAXO);
            check("mon_seq_valid", 32'(seq_valid), 32'(exp_sv));
            check("mon_shf_valid", 32'(shf_valid), 32'(exp_fv));
            if (exp_sv) check("mon_seq_data", 32'(seq_data), 32'(seq_q[0]));
            if (exp_fv) check("mon_shf_data", 32'(shf_data), 32'(shf_q[0]));
            check("mon_idle", 32'(idle), 32'(seq_q.size() == 0 && shf_q.size() == 0 &&
                                             seq_infl == 0 && shf_infl == 0));
            s_hs = exp_sv & seq_ready;
            f_hs = exp_fv & shf_ready;
            check("mon_in_ready", 32'(in_ready),
                  32'((seq_q.size() == 0 || s_hs) && (shf_q.size() == 0 || f_hs)));
            check("mon_err", 32'(err), 32'd0);
            if (s_hs) begin void'(seq_q.pop_front()); seq_infl++; end
            if (f_hs) begin void'(shf_q.pop_front()); shf_infl++; end
            if (seq_done) seq_infl--;
            if (shf_done) shf_infl--;
        end
    end

    initial begin
        logic acc;
        int   guard;
        acc = 1'b0;

        // Reset state
        #12;
        check("rst_seq_valid", 32'(seq_valid), 0);
        check("rst_shf_valid", 32'(shf_valid), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_err", 32'(err), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_seq_data", 32'(seq_data), 0);
        tick();
        rst_n = 1'b1;

        // Single entry
        tick();
        in_valid = 1'b1; in_data = 8'h5A; seq_ready = 1'b1; shf_ready = 1'b1;
        #1 check("t1_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        #1;
        check("t1_seq_valid", 32'(seq_valid), 1);
        check("t1_shf_valid", 32'(shf_valid), 1);
        check("t1_seq_data", 32'(seq_data), 32'h5A);
        check("t1_shf_data", 32'(shf_data), 32'h5A);
        check("t1_busy", 32'(idle), 0);
        tick();
        seq_done = 1'b1; shf_done = 1'b1;
        #1 check("t1_inflight", 32'(idle), 0);
        tick();
        seq_done = 1'b0; shf_done = 1'b0;
        #1 check("t1_idle", 32'(idle), 1);
        check("t1_err", 32'(err), 0);

        // Randomized traffic against the scoreboard
        mon_en = 1'b1;
        repeat (3000) begin
            @(posedge clk);
            if (acc) begin seq_q.push_back(in_data); shf_q.push_back(in_data); end
            #1;
            in_valid  = ($urandom_range(3) != 0);
            in_data   = 8'($urandom);
            seq_ready = ($urandom_range(3) != 0);
            shf_ready = ($urandom_range(2) != 0);
            seq_done  = (seq_infl > 0) && ($urandom_range(2) == 0);
            shf_done  = (shf_infl > 0) && ($urandom_range(3) == 0);
            @(negedge clk);
            acc = in_valid & in_ready;
        end
        guard = 0;
        while ((seq_q.size() > 0 || shf_q.size() > 0 || seq_infl > 0 || shf_infl > 0 || acc)
               && guard < 300) begin
            @(posedge clk);
            if (acc) begin seq_q.push_back(in_data); shf_q.push_back(in_data); end
            #1;
            in_valid  = 1'b0;
            seq_ready = 1'b1;
            shf_ready = 1'b1;
            seq_done  = (seq_infl > 0) && ($urandom_range(1) == 0);
            shf_done  = (shf_infl > 0) && ($urandom_range(1) == 0);
            @(negedge clk);
            acc = 1'b0;
            guard++;
        end
        check("drain_timeout", 32'(guard < 300), 1);
        tick();
        seq_done = 1'b0; shf_done = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        tick();
        check("drain_idle", 32'(idle), 1);

        // Credit exhaustion: five back-to-back entries, no retirement
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(k);
            #1 check("cr_ready", 32'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("cr_seq_blocked", 32'(seq_valid), 0);
        check("cr_shf_blocked", 32'(shf_valid), 0);
        check("cr_in_blocked", 32'(in_ready), 0);
        check("cr_held_data", 32'(seq_data), 32'h14);
        seq_done = 1'b1;
        tick();
        seq_done = 1'b0;
        #1 check("cr_seq_resume", 32'(seq_valid), 1);
        // Handshake and done together at count MAXO-1
        seq_done = 1'b1;
        tick();
        seq_done = 1'b0;
        #1;
        check("sim_seq_sent", 32'(seq_valid), 0);
        check("sim_err", 32'(err), 0);
        shf_done = 1'b1;
        tick();
        shf_done = 1'b0;
        #1 check("cr_shf_resume", 32'(shf_valid), 1);
        tick();
        check("cr_not_idle", 32'(idle), 0);
        for (int j = 0; j < 4; j++) begin
            seq_done = (j < 3); shf_done = 1'b1;
            tick();
        end
        seq_done = 1'b0; shf_done = 1'b0;
        #1;
        check("cr_idle", 32'(idle), 1);
        check("cr_err", 32'(err), 0);

        // Spurious done
        shf_done = 1'b1;
        tick();
        shf_done = 1'b0;
        #1 check("spur_err", 32'(err), 1);
        tick();
        check("spur_sticky", 32'(err), 1);
        check("spur_idle", 32'(idle), 1);

        // Mid-operation reset with an entry held and two seq entries in flight
        seq_ready = 1'b1; shf_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA0;
        tick();
        in_data = 8'hA1;
        tick();
        shf_ready = 1'b1;
        tick();
        in_valid = 1'b0; shf_ready = 1'b0;
        tick();
        #1 check("mr_shf_pending", 32'(shf_valid), 1);
        check("mr_seq_sent", 32'(seq_valid), 0);
        rst_n = 1'b0;
        #1;
        check("mr_shf_drop", 32'(shf_valid), 0);
        check("mr_idle", 32'(idle), 1);
        check("mr_err_clr", 32'(err), 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1 check("mr_ready", 32'(in_ready), 1);
        check("mr_seq_valid", 32'(seq_valid), 0);
        seq_done = 1'b1;
        tick();
        seq_done = 1'b0;
        #1 check("mr_cnt_zero", 32'(err), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/meta_info_dispatcher.md
Name: meta_info_dispatcher

Overview:
- Registered, credit-controlled scheduler that sits between the VLSU control machine and the sequential and shuffle consumer modules.
- Holds one meta_ctrl_t entry and offers it to both consumers. Each consumer may accept in a different cycle.
- Limits how many entries each consumer may have in flight, using completion pulses returned by that consumer.
- Reports idle and protocol-error status.

Parameters:
- meta_ctrl_t, logic, type of the meta-info payload (width W = $bits(meta_ctrl_t)).
- MaxOutstanding, 4, maximum entries in flight per consumer; legal range 1..15.
- CntW, $clog2(MaxOutstanding+1), width of the credit counters.

Ports:
- clk_i  in  1  clock; every register samples on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- meta_info_valid_i  in  1  entry valid from the control machine.
- meta_info_ready_o  out  1  dispatcher accepts the entry this cycle.
- meta_info_i  in  W  meta-info payload.
- seq_valid_o  out  1  entry offered to the sequential consumer.
- seq_ready_i  in  1  sequential consumer accepts.
- seq_o  out  W  payload to the sequential consumer.
- seq_done_i  in  1  one-cycle pulse: sequential consumer retired one entry.
- shf_valid_o  out  1  entry offered to the shuffle consumer.
- shf_ready_i  in  1  shuffle consumer accepts.
- shf_o  out  W  payload to the shuffle consumer.
- shf_done_i  in  1  one-cycle pulse: shuffle consumer retired one entry.
- idle_o  out  1  holding register empty and both in-flight counters are zero.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (asynchronous, rst_ni low):
  - Entry register empty; seq_sent and shf_sent = 0; seq_cnt and shf_cnt = 0; err_o = 0.
  - All valid outputs = 0; idle_o = 1.
  - Payload outputs reset to all-zero.
- Reset asserted mid-operation discards any held entry and all in-flight counts; no further handshake completes.
- Holding register (full flag, payload, seq_sent, shf_sent):
  - seq_o and shf_o are driven from the register.
  - seq_valid_o = full & ~seq_sent & (seq_cnt < MaxOutstanding).
  - shf_valid_o = full & ~shf_sent & (shf_cnt < MaxOutstanding).
- Handshakes:
  - Each output handshake completes on valid & ready in the same cycle and sets that side's sent flag.
  - Valid, once asserted, stays high until the handshake, since the counters can only decrease while valid is high.
- Retire: the entry retires in the cycle where each side is either already sent or handshaking this cycle. On retire, full, seq_sent and shf_sent clear.
- Input ready: meta_info_ready_o = ~full | retire_this_cycle.
  - The retire term is a same-cycle bypass, so back-to-back sustained throughput is one entry per cycle.
  - No combinational path from meta_info_valid_i to any output.
- Latency: an entry accepted in cycle N is presented on seq_valid_o and shf_valid_o in cycle N+1 at the earliest.
- Credit counters (identical rule for each side):
  - +1 on that side's handshake; -1 on that side's done_i.
  - Handshake and done in the same cycle: counter unchanged.
  - done_i with the counter at 0 and no handshake that cycle: counter stays 0 and err_o is set.
  - The counter never exceeds MaxOutstanding; the valid gating guarantees this.
- err_o stays set until reset.
- idle_o = ~full & (seq_cnt == 0) & (shf_cnt == 0), computed combinationally from registers.
- Ordering: entries are delivered to each consumer in acceptance order. A side that has already accepted an entry does not see the next entry until the other side has also accepted the current one.

Optional Feature:
- META_DISPATCH_PERF_EN defined:
  - Adds output ports stall_seq_cnt_o[31:0] and stall_shf_cnt_o[31:0].
  - Each counts cycles where full & ~sent & that side's valid is low because of credit exhaustion.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset-to-single entry:
  - Stimulus: after reset, one entry 0x5A with both ready=1.
  - Response: meta_info_ready_o=1 in cycle 0; seq_valid_o and shf_valid_o both 1 in cycle 1 with payload 0x5A; idle_o=0; after seq_done_i and shf_done_i pulses, idle_o=1.
- Skewed acceptance:
  - Stimulus: shf_ready_i held 0 for 3 cycles, seq_ready_i=1.
  - Response: seq accepts in cycle 1 and seq_valid_o drops in cycle 2; meta_info_ready_o stays 0 until shf accepts in cycle 4, then the next entry appears in cycle 5.
- Credit exhaustion:
  - Stimulus: MaxOutstanding=4, 6 entries streamed, no seq_done_i.
  - Response: seq accepts 4; seq_valid_o low with seq_cnt=4; one seq_done_i pulse lets the 5th entry through the next cycle.
- Simultaneous handshake and done at seq_cnt=4-1:
  - Stimulus: seq handshake and seq_done_i in the same cycle.
  - Response: seq_cnt stays 3; no error.
- Spurious done:
  - Stimulus: shf_done_i pulse with shf_cnt=0.
  - Response: err_o=1 from the next cycle and stays set; shf_cnt stays 0.
- Mid-operation reset:
  - Stimulus: rst_ni low while an entry is held and seq_cnt=2.
  - Response: all valid outputs drop immediately; idle_o=1; counters 0 after release.
